// File: rtl/tank_trouble_soc_usb_gpo.sv
// -----------------------------------------------------------------------------
// tank_trouble_soc_usb_gpo
//   Avalon-MM slave output PIO driving control lines from the NIOS to the USB
//   host controller (USB reset, chip-select override, ...). It provides a plain
//   data register, atomic set/clear aliases and a hardware timed-pulse engine,
//   so software can fire a fixed-width pulse without busy-waiting.
//
//   Register map (word addresses):
//     0 DATA        R/W  (reads 0 unless readback is enabled)
//     1 PULSE_LEN   R/W  PULSE_W bits (reads 0 unless readback is enabled)
//     2 PULSE_TRIG  write = pulse mask, read bit0 = busy
//     4 OUTSET      write-only, data_reg |= writedata
//     5 OUTCLEAR    write-only, data_reg &= ~writedata
//     3,6,7         reserved, writes ignored, reads 0
//
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous, active-high reset
//     address     Avalon word address [2:0]
//     chipselect  Avalon slave select
//     write_n     Avalon write strobe, active low
//     writedata   Avalon write data [31:0]
//     readdata    registered read data [31:0], 1-cycle latency
//     out_port    driven output lines [WIDTH-1:0]
//
//   Optional feature macro: TANK_TROUBLE_USB_GPO_READBACK_EN
//     defined   -> addresses 0/1 read data_reg / PULSE_LEN, zero-extended
//     undefined -> addresses 0/1 read 0 (standard write-only output PIO)
// -----------------------------------------------------------------------------
module tank_trouble_soc_usb_gpo #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      PULSE_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] A_DATA  = 3'd0;
   localparam logic [2:0] A_PLEN  = 3'd1;
   localparam logic [2:0] A_TRIG  = 3'd2;
   localparam logic [2:0] A_SET   = 3'd4;
   localparam logic [2:0] A_CLR   = 3'd5;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     data_reg;
   logic [WIDTH-1:0]     pulse_mask;
   logic [PULSE_W-1:0]   pulse_len;
   logic [PULSE_W-1:0]   cnt;
   logic [31:0]          rd_mux;
   logic                 wr_en;
   logic                 busy;
   logic                 trig_ok;

   // Bits of writedata above WIDTH / PULSE_W are intentionally dropped.
   logic unused_wd;
   assign unused_wd = &{1'b0, writedata};

   assign wr_en   = chipselect & ~write_n;
   assign busy    = (state == ACTIVE);
   // A trigger only starts a pulse from IDLE with a non-zero length; a
   // retrigger while running is dropped so mask and count stay intact.
   assign trig_ok = wr_en && (address == A_TRIG) && !busy && (pulse_len != '0);

   // Pulse FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (trig_ok) state_nxt = ACTIVE;
         ACTIVE:  if (cnt == PULSE_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pulse FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Read mux, sampled into readdata every cycle (no side effects).
   always_comb begin
      rd_mux = '0;
      case (address)
`ifdef TANK_TROUBLE_USB_GPO_READBACK_EN
         A_DATA:  rd_mux = 32'(data_reg);
         A_PLEN:  rd_mux = 32'(pulse_len);
`endif
         A_TRIG:  rd_mux = {31'd0, busy};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg   <= RESET_VALUE;
         pulse_len  <= '0;
         pulse_mask <= '0;
         cnt        <= '0;
         readdata   <= '0;
      end else begin
         readdata <= rd_mux;
         if (wr_en) begin
            case (address)
               A_DATA:  data_reg  <= writedata[WIDTH-1:0];
               A_PLEN:  pulse_len <= writedata[PULSE_W-1:0];
               A_SET:   data_reg  <= data_reg | writedata[WIDTH-1:0];
               A_CLR:   data_reg  <= data_reg & ~writedata[WIDTH-1:0];
               default: ;
            endcase
         end
         // Load on trigger, otherwise count down while running. A PULSE_LEN
         // write mid-pulse only touches the register, never cnt.
         if (trig_ok) begin
            pulse_mask <= writedata[WIDTH-1:0];
            cnt        <= pulse_len;
         end else if (busy) begin
            cnt <= cnt - PULSE_W'(1);
         end
      end
   end

   assign out_port = data_reg | (busy ? pulse_mask : '0);

endmodule

// File: tb/tb_tank_trouble_soc_usb_gpo.sv
module tb_tank_trouble_soc_usb_gpo;

   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'b0001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [W-1:0] out_port;

   always #5 clk = ~clk;

   tank_trouble_soc_usb_gpo #(.WIDTH(W), .RESET_VALUE(RV), .PULSE_W(16)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port)
   );

   typedef struct {
      logic [3:0]  out;
      logic [31:0] rd;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: the pulse is a window of edge indices [p_start, p_end);
   // it is visible after every edge inside the window.
   logic [3:0]  m_data = RV;
   logic [3:0]  m_mask = '0;
   logic [15:0] m_plen = '0;
   int          p_start = 0, p_end = 0;
   int          k = 0;

   function automatic bit in_pulse(input int e);
      return (e >= p_start) && (e < p_end);
   endfunction

   task automatic cyc(input logic r, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] wd);
      exp_t e;
      bit   busy_pre;
      logic [31:0] rd;
      @(negedge clk);
      reset = r; chipselect = cs; write_n = wn; address = a; writedata = wd;
      k++;
      busy_pre = in_pulse(k - 1);
      rd = 32'd0;
`ifdef TANK_TROUBLE_USB_GPO_READBACK_EN
      if (a == 3'd0) rd = {28'd0, m_data};
      if (a == 3'd1) rd = {16'd0, m_plen};
`endif
      if (a == 3'd2) rd = {31'd0, busy_pre};
      if (r) begin
         m_data = RV; m_plen = '0; m_mask = '0; p_start = 0; p_end = 0; rd = 32'd0;
      end else if (cs && !wn) begin
         case (a)
            3'd0: m_data = wd[3:0];
            3'd1: m_plen = wd[15:0];
            3'd2: if (!busy_pre && m_plen != 0) begin
                     p_start = k; p_end = k + int'(m_plen); m_mask = wd[3:0];
                  end
            3'd4: m_data = m_data | wd[3:0];
            3'd5: m_data = m_data & ~wd[3:0];
            default: ;
         endcase
      end
      e.out = m_data | (in_pulse(k) ? m_mask : 4'd0);
      e.rd  = rd;
      e.cyc = k;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d); cyc(1'b0, 1'b1, 1'b0, a, d); endtask
   task automatic rd(input logic [2:0] a); cyc(1'b0, 1'b1, 1'b1, a, $urandom); endtask
   task automatic rst(); cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0); endtask

   // Monitor: the DUT presents out_port/readdata after every edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (out_port !== e.out) begin
            n_fail++;
            $display("FAIL out_port cyc=%0d got=%h exp=%h", e.cyc, out_port, e.out);
         end
         n_chk++;
         if (readdata !== e.rd) begin
            n_fail++;
            $display("FAIL readdata cyc=%0d got=%h exp=%h", e.cyc, readdata, e.rd);
         end
      end
   end

   initial begin
      // Reset held for 3 cycles, then DATA=0 clears the reset value.
      repeat (3) rst();
      rd(3'd2);
      wr(3'd0, 32'd0);
      rd(3'd0);
      // DATA / OUTSET / OUTCLEAR sequence, then a DATA read.
      wr(3'd0, 32'h5); wr(3'd4, 32'h2); wr(3'd5, 32'h4);
      rd(3'd0); rd(3'd1);
      // 5-cycle pulse on bit 0.
      wr(3'd0, 32'd0); wr(3'd1, 32'd5); wr(3'd2, 32'h1);
      repeat (8) rd(3'd2);
      // 10-cycle pulse, retrigger and PULSE_LEN rewrite mid-pulse.
      wr(3'd1, 32'd10); wr(3'd2, 32'h3);
      rd(3'd2); rd(3'd2);
      wr(3'd2, 32'hC); wr(3'd1, 32'd2); wr(3'd5, 32'h1); wr(3'd4, 32'h2);
      repeat (10) rd(3'd2);
      // Zero length trigger is ignored.
      wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd2, 32'hF);
      repeat (3) rd(3'd2);
      // Long pulse cancelled by reset.
      wr(3'd1, 32'hFFFF); wr(3'd2, 32'hF);
      repeat (98) rd(3'd2);
      rst();
      repeat (2) rd(3'd2);
      // Reserved addresses and write-only reads.
      wr(3'd0, 32'h1); wr(3'd1, 32'h7);
      wr(3'd3, 32'hF); wr(3'd6, 32'hF); wr(3'd7, 32'hF);
      rd(3'd0); rd(3'd1); rd(3'd3); rd(3'd6); rd(3'd7); rd(3'd2);
      // Upper bits ignored.
      wr(3'd0, 32'hFFFF_FFF2); rd(3'd0);
      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [2:0]  a;
         logic [31:0] d;
         a = 3'($urandom_range(0, 7));
         d = $urandom;
         if (a == 3'd1) d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 20));
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 1) == 1), a, d);
      end
      cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
      repeat (3) @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tank_trouble_soc_usb_gpo.md
Name: tank_trouble_soc_usb_gpo

Overview:
- Avalon-MM slave output PIO that drives general-purpose control lines from the NIOS to the USB host controller (e.g. USB reset, chip-select override).
- It is the write/drive counterpart of the USB GPX input PIO.
- Provides a plain data register, atomic set/clear aliases, and a hardware timed-pulse engine, so software can issue a fixed-width reset pulse without busy-waiting.

Parameters:
- WIDTH, 1, number of output bits driven on out_port (1..32).
- RESET_VALUE, 0, value loaded into the data register on reset (WIDTH bits).
- PULSE_W, 16, width of the pulse-length register and counter, in bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  Avalon write data; bits above WIDTH (or above PULSE_W for PULSE_LEN) are ignored.
- readdata  out  32  registered Avalon read data.
- out_port  out  WIDTH  driven output lines.

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Register map (word addresses):
  - 0 DATA: R/W.
  - 1 PULSE_LEN: R/W, PULSE_W bits.
  - 2 PULSE_TRIG: write mask; read bit0 = busy.
  - 4 OUTSET: write-only, reads 0.
  - 5 OUTCLEAR: write-only, reads 0.
  - 3, 6, 7: reserved; writes ignored, reads 0.
- Writes take effect at the clock edge where the write is sampled:
  - DATA: data_reg <= writedata.
  - OUTSET: data_reg <= data_reg | writedata.
  - OUTCLEAR: data_reg <= data_reg & ~writedata.
- out_port = data_reg | (busy ? pulse_mask : 0). It is a combinational function of registers only, so it changes 1 cycle after the write edge.
- Pulse FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE: on a PULSE_TRIG write with PULSE_LEN != 0. Latch pulse_mask <= writedata[WIDTH-1:0] and cnt <= PULSE_LEN.
  - In ACTIVE, busy=1 and cnt decrements every cycle.
  - ACTIVE -> IDLE: when cnt == 1 at a clock edge; busy drops at that edge.
  - Result: mask bits are ORed onto out_port for exactly PULSE_LEN cycles, starting the cycle after the trigger edge.
- Boundary conditions:
  - PULSE_TRIG write while ACTIVE: ignored; no retrigger, mask and count unchanged.
  - PULSE_TRIG write with PULSE_LEN == 0: ignored; stays IDLE.
  - PULSE_LEN write while ACTIVE: updates the register only; the running count is unaffected.
  - DATA/OUTSET/OUTCLEAR writes during a pulse: update data_reg normally; the pulse OR still applies. Clearing a bit that is in pulse_mask has no visible effect until the pulse ends.
  - Mask bits already set in data_reg: stay high after the pulse ends.
- Read path:
  - readdata <= mux(address) every clock; 1-cycle read latency.
  - No read strobe needed; reads have no side effects.
  - Unused upper bits read 0.
- Reset (synchronous, including mid-pulse):
  - data_reg <= RESET_VALUE, PULSE_LEN <= 0, cnt <= 0, pulse_mask <= 0, state <= IDLE, readdata <= 0.
  - out_port = RESET_VALUE from the cycle after the reset edge.
  - Any in-flight pulse is cancelled.

Optional Feature:
- Macro: TANK_TROUBLE_USB_GPO_READBACK_EN.
- Defined: address 0 reads data_reg (not out_port), and address 1 reads PULSE_LEN, both zero-extended.
- Undefined: addresses 0 and 1 read 0 (write-only, matching a standard output PIO); the PULSE_TRIG busy bit remains readable.
- Write behaviour is identical either way.

Test Plan:
- Reset with RESET_VALUE=1, WIDTH=1: hold reset 3 cycles -> out_port=1, readdata=0, busy=0; a DATA write of 0 -> out_port=0 next cycle.
- WIDTH=4, DATA=4'b0101, then OUTSET 4'b0010, then OUTCLEAR 4'b0100 -> out_port 0101 -> 0111 -> 0011. With readback enabled, a DATA read returns 0x3 one cycle after the address is presented.
- PULSE_LEN=5, DATA=0, PULSE_TRIG mask=1 -> out_port[0]=1 for exactly 5 cycles starting the cycle after the write; busy reads 1 during the pulse and 0 afterwards.
- During a 10-cycle pulse: re-trigger at cycle 3, and write PULSE_LEN=2 -> pulse still lasts 10 cycles in total.
- PULSE_LEN=0, trigger -> out_port unchanged, busy=0. Then PULSE_LEN=0xFFFF, trigger, assert reset at cycle 100 -> out_port=RESET_VALUE and busy=0 the next cycle.
- Without READBACK_EN: write DATA=1 and PULSE_LEN=7, read addresses 0 and 1 -> both 0; reads of addresses 3, 6, 7 -> 0; out_port=1.
